sector_mapper_pipe: RTL and testbench
=====================================

Name: sector_mapper_pipe

Overview:
- Parametrised, pipelined successor of the fixed six-sextant mapper. Maps each screen pixel to one of NUM_SECTORS rotating angular sectors and to its polygonal radius, which is the distance along that sector's centre direction.
- Sits between the VGA pixel counters and the playfield colour logic.
- Per-sector sin/cos coefficients are computed once per frame by a small load sequencer, not per pixel. Pixels stream through a fixed-latency pipeline with valid tagging.

Parameters:
- COORD_W, 10, width of DrawX/DrawY.
- ANGLE_W, 10, angle width; one full turn is 2**ANGLE_W.
- NUM_SECTORS, 6, number of sectors (3..16).
- TRIG_FRAC, 10, fractional bits of the sin/cos coefficients (signed Q1.TRIG_FRAC).
- RADIUS_W, 10, radius output width.
- CENTER_X, 320, origin X.
- CENTER_Y, 240, origin Y.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse; samples rotation_offset and starts a coefficient load
- rotation_offset  in  ANGLE_W  sector-0 boundary angle
- in_valid  in  1  pixel present
- DrawX  in  COORD_W  pixel x
- DrawY  in  COORD_W  pixel y
- coef_ready  out  1  a coefficient bank is active; pixels are accepted
- coef_busy  out  1  a load is in progress
- out_valid  out  1  result valid
- sector  out  SECT_W  sector number, 1..NUM_SECTORS
- radius  out  RADIUS_W  polygonal radius in pixels

Behaviour:
- Reset (asynchronous):
  - all outputs 0, both coefficient banks 0, FSM in INIT, pipeline valids 0.
  - On the first clock after Reset deasserts, the block behaves as if frame_start had been pulsed.
- Constants:
  - STEP = (2**ANGLE_W + NUM_SECTORS/2) / NUM_SECTORS, which is 171 for the defaults.
  - Direction of sector k (k = 0..N-1): dir_k = rotation_offset + STEP/2 + k*STEP, mod 2**ANGLE_W. For the defaults this is rot + 85 + 171k.
- Load FSM states: INIT, IDLE, LOAD.
  - frame_start at cycle t in IDLE or LOAD: latch rotation_offset, set k = 0, go to LOAD.
  - In LOAD, issue angle dir_k at cycles t+1..t+N. The lookup returns one cycle later and is written to the shadow bank at t+2..t+N+1.
  - At the end of cycle t+N+1: swap shadow and active banks, set coef_ready = 1, return to IDLE.
  - coef_busy is high for cycles t+1..t+N+1.
  - frame_start during LOAD restarts the load from k = 0 with the new rotation. The active bank is untouched.
  - Reset during LOAD aborts the load; the reset values apply.
- Pixel pipeline, latency 4: in_valid at cycle c gives out_valid at c+4. No backpressure.
  - A pixel is accepted only if in_valid and coef_ready are both high in the same cycle. Otherwise it is dropped and produces no out_valid.
  - S1: X = CENTER_X - DrawX and Y = CENTER_Y - DrawY, signed COORD_W+1 bits. The active bank is sampled with the pixel, so a pixel is never computed with mixed banks.
  - S2: d_k = X*cos_k + Y*sin_k for all k. Width COORD_W + TRIG_FRAC + 3, signed, full precision, no truncation.
  - S3: argmax over d_k. Ties go to the lowest k. Register kmax and dmax.
  - S4: sector = kmax + 1.
  - S4: radius = dmax >>> TRIG_FRAC (floor). Clamp negative results to 0. Saturate to 2**RADIUS_W - 1.
- The bank swap takes effect for pixels accepted at cycle t+N+2 onward. Earlier pixels still in flight finish with the old bank.
- SECT_W = $clog2(NUM_SECTORS+1).

Decomposition:
- Package sector_pkg holds:
  - function sector_step(N, ANGLE_W) returning STEP;
  - the signed coefficient typedef coef_t, TRIG_FRAC+2 bits;
  - the load FSM state enum.
- Sub-module sincos_lut:
  - quarter-wave ROM with 1-cycle registered latency;
  - input angle of ANGLE_W bits; outputs sin and cos as coef_t;
  - exact values at the cardinal angles, e.g. angle 256 gives sin = 1024, cos = 0.
  - One instance, shared by the load FSM.

Test Plan:
1. Reset, then idle until coef_ready (rotation 0). Pixel (320,140), so X=0, Y=100 -> 4 cycles later out_valid=1, sector=2, radius=100.
2. Pixel (320,240), the origin -> all d_k=0, tie goes to lowest k -> sector=1, radius=0.
3. Continuous pixel stream of (320,140); frame_start at t with rotation_offset=171 -> coef_busy high t+1..t+7; pixels accepted up to t+7 give sector=2; pixels from t+8 give sector=1, radius=100.
4. Wrap-around: rotation_offset=1000, pixel (320,140) -> directions 61, 232, ...; sector=2, radius=98.
5. Instance with RADIUS_W=8, pixel (0,0), X=320, Y=240 -> sector=1, radius saturates to 255.
6. Three control cases:
   - frame_start again 3 cycles into a load -> coef_busy extends to 7 cycles after the second pulse, and only the second rotation is applied.
   - in_valid during the initial load (coef_ready=0) -> no out_valid.
   - Reset asserted mid-load -> all outputs 0 immediately, then the automatic reload runs.

Source files
------------

// File: rtl/sector_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sector_pkg                                                       |
// | Shared types and constants for the sector mapper pipeline.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package sector_pkg;

  // The coefficient type is sized for this fractional width.
  localparam int TRIG_FRAC_DFLT = 10;

  typedef logic signed [TRIG_FRAC_DFLT+1:0] coef_t;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_LOAD = 2'd2
  } load_state_t;

  // Angular width of one sector, rounded to nearest.
  function automatic int sector_step(input int n, input int angle_w);
    return ((2 ** angle_w) + n / 2) / n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sector_mapper_pipe_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sector_mapper_pipe_if                                            |
// | Pixel, frame control and result bundle of the sector mapper.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface sector_mapper_pipe_if #(
  parameter int COORD_W  = 10,
  parameter int ANGLE_W  = 10,
  parameter int RADIUS_W = 10,
  parameter int SECT_W   = 3
);
  logic                frame_start;
  logic [ANGLE_W-1:0]  rotation_offset;
  logic                in_valid;
  logic [COORD_W-1:0]  DrawX;
  logic [COORD_W-1:0]  DrawY;
  logic                coef_ready;
  logic                coef_busy;
  logic                out_valid;
  logic [SECT_W-1:0]   sector;
  logic [RADIUS_W-1:0] radius;

  modport master (
    output frame_start, rotation_offset, in_valid, DrawX, DrawY,
    input  coef_ready, coef_busy, out_valid, sector, radius
  );

  modport slave (
    input  frame_start, rotation_offset, in_valid, DrawX, DrawY,
    output coef_ready, coef_busy, out_valid, sector, radius
  );
endinterface
`default_nettype wire

// File: rtl/sincos_lut.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sincos_lut                                                       |
// | Quarter-wave sin/cos ROM, one registered cycle of latency.       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module sincos_lut
  import sector_pkg::*;
#(
  parameter int ANGLE_W   = 10,
  parameter int TRIG_FRAC = TRIG_FRAC_DFLT
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [ANGLE_W-1:0] i_angle,
  output coef_t              o_sin,
  output coef_t              o_cos
);

  localparam int c_IDX_W   = ANGLE_W - 2;
  localparam int c_QUARTER = 2 ** c_IDX_W;

  // Entry c_QUARTER holds sin(90 deg) so the mirrored index never wraps.
  coef_t w_rom [c_QUARTER+1];

  for (genvar gi = 0; gi <= c_QUARTER; gi++) begin : g_rom
    localparam real c_PHI = 6.283185307179586 * gi / (2.0 ** ANGLE_W);
    localparam int  c_VAL = $rtoi($sin(c_PHI) * (2.0 ** TRIG_FRAC) + 0.5);
    assign w_rom[gi] = coef_t'(c_VAL);
  end

  logic [1:0]       w_quad;
  logic [c_IDX_W:0] w_fwd_idx;
  logic [c_IDX_W:0] w_rev_idx;
  coef_t            w_fwd;
  coef_t            w_rev;
  coef_t            w_sin;
  coef_t            w_cos;

  always_comb begin
    w_quad    = i_angle[ANGLE_W-1 -: 2];
    w_fwd_idx = {1'b0, i_angle[c_IDX_W-1:0]};
    w_rev_idx = (c_IDX_W+1)'(c_QUARTER) - w_fwd_idx;
    w_fwd     = w_rom[w_fwd_idx];
    w_rev     = w_rom[w_rev_idx];
    w_sin     = w_fwd;
    w_cos     = w_rev;
    case (w_quad)
      2'd0: begin w_sin = w_fwd;  w_cos = w_rev;  end
      2'd1: begin w_sin = w_rev;  w_cos = -w_fwd; end
      2'd2: begin w_sin = -w_fwd; w_cos = -w_rev; end
      default: begin w_sin = -w_rev; w_cos = w_fwd; end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      o_sin <= '0;
      o_cos <= '0;
    end else begin
      o_sin <= w_sin;
      o_cos <= w_cos;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sector_mapper_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sector_mapper_pipe                                               |
// | Per-frame coefficient loader plus 4-stage sector/radius pipeline.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module sector_mapper_pipe
  import sector_pkg::*;
#(
  parameter int COORD_W     = 10,
  parameter int ANGLE_W     = 10,
  parameter int NUM_SECTORS = 6,
  parameter int TRIG_FRAC   = TRIG_FRAC_DFLT,
  parameter int RADIUS_W    = 10,
  parameter int CENTER_X    = 320,
  parameter int CENTER_Y    = 240
) (
  input  logic                 Clk,
  input  logic                 Reset,
  sector_mapper_pipe_if.slave  bus
);

  localparam int SECT_W = $clog2(NUM_SECTORS + 1);
  localparam int c_STEP = sector_step(NUM_SECTORS, ANGLE_W);
  localparam int c_K_W  = $clog2(NUM_SECTORS);
  localparam int c_XY_W = COORD_W + 1;
  localparam int c_D_W  = COORD_W + TRIG_FRAC + 3;

  localparam logic [ANGLE_W-1:0]       c_STEP_A = ANGLE_W'(c_STEP);
  localparam logic [ANGLE_W-1:0]       c_HALF_A = ANGLE_W'(c_STEP / 2);
  localparam logic [SECT_W-1:0]        c_LAST   = SECT_W'(NUM_SECTORS);
  localparam logic signed [c_D_W-1:0]  c_RMAX   = c_D_W'((2 ** RADIUS_W) - 1);

  load_state_t        r_state;
  logic [ANGLE_W-1:0] r_dir;
  logic [SECT_W-1:0]  r_k;
  logic               r_busy;
  logic               r_ready;
  logic               r_act;
  logic               r_wr_en;
  logic [c_K_W-1:0]   r_wr_idx;
  coef_t              w_lut_sin;
  coef_t              w_lut_cos;
  coef_t              r_sin [2][NUM_SECTORS];
  coef_t              r_cos [2][NUM_SECTORS];

  sincos_lut #(
    .ANGLE_W   (ANGLE_W),
    .TRIG_FRAC (TRIG_FRAC)
  ) u_lut (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_angle (r_dir),
    .o_sin   (w_lut_sin),
    .o_cos   (w_lut_cos)
  );

  // r_dir walks the sector centres; r_k == NUM_SECTORS is the drain cycle for the last lookup.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= ST_INIT;
      r_dir    <= '0;
      r_k      <= '0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
      r_act    <= 1'b0;
      r_wr_en  <= 1'b0;
      r_wr_idx <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (r_state == ST_LOAD && r_k < c_LAST) begin
        r_wr_en  <= 1'b1;
        r_wr_idx <= r_k[c_K_W-1:0];
      end
      if (r_state == ST_INIT || bus.frame_start) begin
        r_dir   <= bus.rotation_offset + c_HALF_A;
        r_k     <= '0;
        r_busy  <= 1'b1;
        r_state <= ST_LOAD;
      end else if (r_state == ST_LOAD) begin
        if (r_k == c_LAST) begin
          r_act   <= ~r_act;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end else begin
          r_k   <= r_k + SECT_W'(1);
          r_dir <= r_dir + c_STEP_A;
        end
      end
    end
  end

  // The final write and the swap share an edge, so the new active bank is complete.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < NUM_SECTORS; k++) begin
          r_sin[b][k] <= '0;
          r_cos[b][k] <= '0;
        end
      end
    end else if (r_wr_en) begin
      r_sin[~r_act][r_wr_idx] <= w_lut_sin;
      r_cos[~r_act][r_wr_idx] <= w_lut_cos;
    end
  end

  assign bus.coef_ready = r_ready;
  assign bus.coef_busy  = r_busy;

  logic                     w_accept;
  logic                     r_s1_v;
  logic signed [c_XY_W-1:0] r_s1_x;
  logic signed [c_XY_W-1:0] r_s1_y;
  logic                     r_s1_bank;

  assign w_accept = bus.in_valid & r_ready;

  // Carrying the bank select is enough: a bank is never rewritten while a pixel using it is in S2.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_s1_v    <= 1'b0;
      r_s1_x    <= '0;
      r_s1_y    <= '0;
      r_s1_bank <= 1'b0;
    end else begin
      r_s1_v <= w_accept;
      if (w_accept) begin
        r_s1_x    <= c_XY_W'(CENTER_X) - c_XY_W'(bus.DrawX);
        r_s1_y    <= c_XY_W'(CENTER_Y) - c_XY_W'(bus.DrawY);
        r_s1_bank <= r_act;
      end
    end
  end

  logic signed [c_D_W-1:0] w_d    [NUM_SECTORS];
  logic signed [c_D_W-1:0] r_s2_d [NUM_SECTORS];
  logic                    r_s2_v;

  for (genvar gk = 0; gk < NUM_SECTORS; gk++) begin : g_dot
    assign w_d[gk] = c_D_W'(r_s1_x) * c_D_W'(r_cos[r_s1_bank][gk])
                   + c_D_W'(r_s1_y) * c_D_W'(r_sin[r_s1_bank][gk]);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_s2_v <= 1'b0;
      for (int k = 0; k < NUM_SECTORS; k++) r_s2_d[k] <= '0;
    end else begin
      r_s2_v <= r_s1_v;
      for (int k = 0; k < NUM_SECTORS; k++) r_s2_d[k] <= w_d[k];
    end
  end

  logic signed [c_D_W-1:0] w_best_d;
  logic [c_K_W-1:0]        w_best_k;
  logic signed [c_D_W-1:0] r_s3_d;
  logic [c_K_W-1:0]        r_s3_k;
  logic                    r_s3_v;

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    w_best_d = r_s2_d[0];
    w_best_k = '0;
    for (int k = 1; k < NUM_SECTORS; k++) begin
      if (r_s2_d[k] > w_best_d) begin
        w_best_d = r_s2_d[k];
        w_best_k = c_K_W'(k);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_s3_v <= 1'b0;
      r_s3_d <= '0;
      r_s3_k <= '0;
    end else begin
      r_s3_v <= r_s2_v;
      r_s3_d <= w_best_d;
      r_s3_k <= w_best_k;
    end
  end

  logic signed [c_D_W-1:0] w_shift;
  logic [RADIUS_W-1:0]     w_radius;
  logic                    r_out_valid;
  logic [SECT_W-1:0]       r_sector;
  logic [RADIUS_W-1:0]     r_radius;

  always_comb begin
    w_shift = r_s3_d >>> TRIG_FRAC;
    if (w_shift[c_D_W-1]) begin
      w_radius = '0;
    end else if (w_shift > c_RMAX) begin
      w_radius = '1;
    end else begin
      w_radius = w_shift[RADIUS_W-1:0];
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_out_valid <= 1'b0;
      r_sector    <= '0;
      r_radius    <= '0;
    end else begin
      r_out_valid <= r_s3_v;
      if (r_s3_v) begin
        r_sector <= SECT_W'(r_s3_k) + SECT_W'(1);
        r_radius <= w_radius;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.sector    = r_sector;
  assign bus.radius    = r_radius;

endmodule
`default_nettype wire

// File: tb/tb_sector_mapper_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_sector_mapper_pipe                                            |
// | Directed vectors for the sector mapper, default and 8-bit radius.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_sector_mapper_pipe;

  logic       Clk;
  logic       Reset;
  logic       frame_start;
  logic [9:0] rot;
  logic       in_valid;
  logic [9:0] drawx;
  logic [9:0] drawy;

  int n_vec = 0;
  int n_err = 0;
  int ov_cnt = 0;

  sector_mapper_pipe_if #(.COORD_W(10), .ANGLE_W(10), .RADIUS_W(10), .SECT_W(3)) if0 ();
  sector_mapper_pipe_if #(.COORD_W(10), .ANGLE_W(10), .RADIUS_W(8),  .SECT_W(3)) if8 ();

  assign if0.frame_start     = frame_start;
  assign if0.rotation_offset = rot;
  assign if0.in_valid        = in_valid;
  assign if0.DrawX           = drawx;
  assign if0.DrawY           = drawy;
  assign if8.frame_start     = frame_start;
  assign if8.rotation_offset = rot;
  assign if8.in_valid        = in_valid;
  assign if8.DrawX           = drawx;
  assign if8.DrawY           = drawy;

  sector_mapper_pipe dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (if0)
  );

  sector_mapper_pipe #(.RADIUS_W(8)) dut8 (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (if8)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int r);
    frame_start = 1'b1;
    rot = 10'(r);
    tick();
    frame_start = 1'b0;
  endtask

  // Called just after the edge that started a load; busy must last 7 cycles.
  task automatic load_wait(input string tag);
    int n = 0;
    while (if0.coef_busy === 1'b1 && n < 40) begin
      if (if0.out_valid === 1'b1) ov_cnt++;
      n++;
      tick();
    end
    chk({tag, "_busy_len"}, n, 7);
    chk({tag, "_ready"}, {31'd0, if0.coef_ready}, 1);
  endtask

  task automatic pixel(input string tag, input int x, input int y, input int es, input int er);
    drawx = 10'(x);
    drawy = 10'(y);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk({tag, "_early"}, {31'd0, if0.out_valid}, 0);
    tick();
    chk({tag, "_valid"}, {31'd0, if0.out_valid}, 1);
    chk({tag, "_sector"}, {29'd0, if0.sector}, es);
    chk({tag, "_radius"}, {22'd0, if0.radius}, er);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    frame_start = 1'b0;
    rot = '0;
    in_valid = 1'b0;
    drawx = '0;
    drawy = '0;
    repeat (3) tick();
    chk("rst_ready", {31'd0, if0.coef_ready}, 0);
    chk("rst_busy", {31'd0, if0.coef_busy}, 0);
    chk("rst_valid", {31'd0, if0.out_valid}, 0);
    chk("rst_sector", {29'd0, if0.sector}, 0);
    chk("rst_radius", {22'd0, if0.radius}, 0);

    // Automatic load after reset, with pixels offered that must be dropped.
    drawx = 10'd320;
    drawy = 10'd140;
    in_valid = 1'b1;
    Reset = 1'b0;
    tick();
    ov_cnt = 0;
    load_wait("init");
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (if0.out_valid === 1'b1) ov_cnt++;
    end
    chk("init_dropped", ov_cnt, 0);

    pixel("top", 320, 140, 2, 100);
    pixel("origin", 320, 240, 1, 0);
    pixel("corner", 0, 0, 1, 397);
    chk("corner_r8_valid", {31'd0, if8.out_valid}, 1);
    chk("corner_r8_sector", {29'd0, if8.sector}, 1);
    chk("corner_r8_radius", {24'd0, if8.radius}, 255);

    // Streaming pixels across a bank swap.
    drawx = 10'd320;
    drawy = 10'd140;
    in_valid = 1'b1;
    repeat (4) tick();
    frame_start = 1'b1;
    rot = 10'd171;
    for (int i = 1; i <= 12; i++) begin
      tick();
      frame_start = 1'b0;
      if (i == 1) chk("swap_busy_t1", {31'd0, if0.coef_busy}, 1);
      if (i == 7) chk("swap_busy_t7", {31'd0, if0.coef_busy}, 1);
      if (i == 8) begin
        chk("swap_busy_t8", {31'd0, if0.coef_busy}, 0);
        chk("swap_ready_t8", {31'd0, if0.coef_ready}, 1);
      end
      if (i == 11) chk("swap_old_bank", {29'd0, if0.sector}, 2);
      if (i == 12) begin
        chk("swap_new_valid", {31'd0, if0.out_valid}, 1);
        chk("swap_new_sector", {29'd0, if0.sector}, 1);
        chk("swap_new_radius", {22'd0, if0.radius}, 100);
      end
    end
    in_valid = 1'b0;
    repeat (4) tick();

    pulse(1000);
    load_wait("wrap");
    pixel("wrap", 320, 140, 2, 98);

    // Restart three cycles into a load; only the second rotation may land.
    pulse(171);
    tick();
    tick();
    pulse(0);
    load_wait("restart");
    pixel("restart", 320, 140, 2, 100);

    // Reset in the middle of a load clears everything at once.
    pulse(171);
    tick();
    tick();
    #2;
    Reset = 1'b1;
    #1;
    chk("midrst_ready", {31'd0, if0.coef_ready}, 0);
    chk("midrst_busy", {31'd0, if0.coef_busy}, 0);
    chk("midrst_valid", {31'd0, if0.out_valid}, 0);
    chk("midrst_sector", {29'd0, if0.sector}, 0);
    chk("midrst_radius", {22'd0, if0.radius}, 0);
    rot = 10'd0;
    tick();
    Reset = 1'b0;
    tick();
    load_wait("reload");
    pixel("reload", 320, 140, 2, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
